// File: rtl/uart_word_tx_pkg.sv
// Shared constants for the frame word UART transmitter.
// The frame markers are also used by the upstream address/enable generator.
package uart_word_tx_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic UART_IDLE = 1'b1;

    localparam logic [15:0] FRAME_HEADER  = 16'h5353;
    localparam logic [15:0] FRAME_TRAILER = 16'h4545;

    // Byte of a word that goes on the line for the first (second=0) or second slot.
    function automatic logic [7:0] select_byte(input logic [15:0] word,
                                               input logic        second,
                                               input logic        hi_first);
        return (second ^ hi_first) ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/uart_word_tx_if.sv
// Word-strobe input and UART/status outputs of uart_word_tx.
// master = upstream generator side, slave = transmitter side.
interface uart_word_tx_if;

    logic [15:0] data_in;
    logic        tx_en;
    logic        txd;
    logic        busy;
    logic        fifo_full;
    logic        overflow;

    modport master (
        output data_in, tx_en,
        input  txd, busy, fifo_full, overflow
    );

    modport slave (
        input  data_in, tx_en,
        output txd, busy, fifo_full, overflow
    );

endinterface

// File: rtl/uart_word_tx_word_fifo.sv
// Small synchronous word FIFO with registered count/full/empty.
// A write into a full FIFO is accepted when a read happens in the same cycle.
module word_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_ok;
    logic             rd_ok;
    logic [CNT_W-1:0] count_nxt;

    assign rd_ok     = rd_en && !empty;
    assign wr_ok     = wr_en && (!full || rd_ok);
    assign count_nxt = count + CNT_W'(wr_ok) - CNT_W'(rd_ok);
    assign rd_data   = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    // NOTE: non-blocking assignments make every register here see pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/uart_word_tx.sv
// Buffers 16-bit frame words and serialises each as two back-to-back UART 8N1 bytes.
// Dropped words (write into a full FIFO with no pop) set a sticky overflow flag.
module uart_word_tx
    import uart_word_tx_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4,
    parameter int HI_FIRST   = 1
) (
    input logic          clk,
    input logic          rst_n,
    uart_word_tx_if.slave bus
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
    localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_idx_nxt;
    logic              byte_sel;
    logic [15:0]       hold;
    logic              txd_q;
    logic              txd_nxt;
    logic              busy_q;
    logic              overflow_q;

    logic [15:0]       fifo_rd_data;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  count_nxt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              wr_acc;
    logic              bit_end;
    logic [7:0]        cur_byte;

    assign pop       = (state == ST_IDLE) && !fifo_empty;
    assign wr_acc    = bus.tx_en && (!fifo_full || pop);
    assign count_nxt = fifo_count + CNT_W'(wr_acc) - CNT_W'(pop);
    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign cur_byte  = select_byte(hold, byte_sel, HI_FIRST != 0);

    word_fifo #(
        .WIDTH(16),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (bus.tx_en),
        .wr_data(bus.data_in),
        .rd_en  (pop),
        .rd_data(fifo_rd_data),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        bit_idx_nxt = bit_idx;
        case (state)
            ST_IDLE:  if (!fifo_empty) state_nxt = ST_START;
            ST_START: if (bit_end) begin
                state_nxt   = ST_DATA;
                bit_idx_nxt = '0;
            end
            ST_DATA:  if (bit_end) begin
                if (bit_idx == 3'd7) state_nxt = ST_STOP;
                else                 bit_idx_nxt = bit_idx + 3'd1;
            end
            ST_STOP:  if (bit_end) state_nxt = byte_sel ? ST_IDLE : ST_START;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Line level is registered from the next state so txd changes exactly on state/bit edges.
    always_comb begin
        txd_nxt = UART_IDLE;
        case (state_nxt)
            ST_START: txd_nxt = 1'b0;
            ST_DATA:  txd_nxt = cur_byte[bit_idx_nxt];
            default:  txd_nxt = UART_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            byte_sel   <= 1'b0;
            hold       <= '0;
            txd_q      <= UART_IDLE;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_idx  <= bit_idx_nxt;
            txd_q    <= txd_nxt;
            busy_q   <= (state_nxt != ST_IDLE) || (count_nxt != '0);
            baud_cnt <= (state == ST_IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
            if (pop) begin
                hold     <= fifo_rd_data;
                byte_sel <= 1'b0;
            end else if (state == ST_STOP && bit_end) begin
                byte_sel <= 1'b1;
            end
            if (bus.tx_en && fifo_full && !pop) overflow_q <= 1'b1;
        end
    end

    assign bus.txd       = txd_q;
    assign bus.busy      = busy_q;
    assign bus.fifo_full = fifo_full;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: line traces are compared against
// expected 8N1 waveforms built directly from the word values.
module tb_uart_word_tx;
    import uart_word_tx_pkg::*;

    localparam int TR       = 32768;
    localparam int WORD_CYC = 321;  // 320 line cycles per word plus one idle cycle

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_asserts = 0;
    int   n_fail    = 0;

    logic txd_a  [TR];
    logic busy_a [TR];
    logic ovf_a  [TR];
    logic txd_b  [TR];

    logic [15:0] wq [$];

    uart_word_tx_if ifa ();
    uart_word_tx_if ifb ();

    uart_word_tx #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(4), .HI_FIRST(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );

    uart_word_tx #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(4), .HI_FIRST(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < TR) begin
            txd_a[15'(cyc)]  <= ifa.txd;
            busy_a[15'(cyc)] <= ifa.busy;
            ovf_a[15'(cyc)]  <= ifa.overflow;
            txd_b[15'(cyc)]  <= ifb.txd;
        end
    end

    task automatic check(input string tag, input logic [321:0] obs, input logic [321:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Idle, then two 8N1 bytes with 16 cycles per bit, then idle.
    function automatic logic [321:0] frame_bits(input logic [15:0] w, input bit hi_first);
        logic [321:0] v;
        logic [7:0]   bytes [2];
        int           pos;
        bytes[0] = hi_first ? w[15:8] : w[7:0];
        bytes[1] = hi_first ? w[7:0]  : w[15:8];
        v   = '1;
        pos = 1;
        for (int b = 0; b < 2; b++) begin
            for (int t = 0; t < 10; t++) begin
                logic lvl;
                lvl = (t == 0) ? 1'b0 : (t == 9) ? 1'b1 : bytes[1'(b)][3'(t - 1)];
                for (int c = 0; c < 16; c++) begin
                    v[9'(pos)] = lvl;
                    pos++;
                end
            end
        end
        return v;
    endfunction

    task automatic wait_past(input int idx);
        while (cyc <= idx) @(negedge clk);
    endtask

    task automatic send_burst(input bit use_b, output int k);
        @(negedge clk);
        k = cyc;
        foreach (wq[i]) begin
            if (use_b) begin
                ifb.data_in = wq[i];
                ifb.tx_en   = 1'b1;
            end else begin
                ifa.data_in = wq[i];
                ifa.tx_en   = 1'b1;
            end
            @(negedge clk);
        end
        ifa.tx_en = 1'b0;
        ifb.tx_en = 1'b0;
    endtask

    task automatic check_frames(input bit use_b, input int k, input bit hi_first, input string tag);
        logic [321:0] act;
        foreach (wq[j]) begin
            int base;
            base = k + 1 + WORD_CYC * j;
            wait_past(base + 321);
            for (int i = 0; i < 322; i++)
                act[9'(i)] = use_b ? txd_b[15'(base + i)] : txd_a[15'(base + i)];
            check($sformatf("%s_w%0d", tag, j), act, frame_bits(wq[j], hi_first));
        end
    endtask

    initial begin
        int          k;
        int          s;
        bit          ok_txd;
        bit          ok_busy;
        bit          ok_ovf;
        logic [15:0] w0;
        logic [15:0] w1;

        ifa.tx_en = 1'b0; ifa.data_in = '0;
        ifb.tx_en = 1'b0; ifb.data_in = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state and 100 idle cycles.
        check("rst_txd",  ifa.txd, 1);
        check("rst_busy", ifa.busy, 0);
        check("rst_full", ifa.fifo_full, 0);
        check("rst_ovf",  ifa.overflow, 0);
        k = cyc;
        wait_past(k + 100);
        ok_txd = 1; ok_busy = 1; ok_ovf = 1;
        for (int i = k; i < k + 100; i++) begin
            if (txd_a[15'(i)] !== 1'b1)  ok_txd  = 0;
            if (busy_a[15'(i)] !== 1'b0) ok_busy = 0;
            if (ovf_a[15'(i)] !== 1'b0)  ok_ovf  = 0;
        end
        check("idle_txd",  ok_txd, 1);
        check("idle_busy", ok_busy, 1);
        check("idle_ovf",  ok_ovf, 1);

        // Single header word: start bit two edges after the strobe, busy ends after second stop.
        wq = '{FRAME_HEADER};
        send_burst(0, k);
        check_frames(0, k, 1, "single");
        check("single_busy_rise", busy_a[15'(k + 1)], 1);
        check("single_busy_stop", busy_a[15'(k + 321)], 1);
        check("single_busy_fall", busy_a[15'(k + 322)], 0);

        // Three consecutive strobes, one idle cycle between words.
        wq = '{FRAME_HEADER, 16'h1234, FRAME_TRAILER};
        send_burst(0, k);
        check_frames(0, k, 1, "three");
        check("three_ovf", ifa.overflow, 0);

        // Six strobes into depth 4: first word popped, four buffered, sixth dropped.
        wq = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
        send_burst(0, k);
        check("six_full", ifa.fifo_full, 1);
        check("six_ovf_set", ifa.overflow, 1);
        check("six_ovf_before", ovf_a[15'(k + 5)], 0);
        wq.delete(5);
        check_frames(0, k, 1, "six");
        check("six_busy_end", busy_a[15'(k + 1 + WORD_CYC * 5)], 0);
        check("six_ovf_sticky", ifa.overflow, 1);

        // Reset during data bit 3 of the first byte, with a second word still buffered.
        w0 = 16'($urandom);
        w1 = 16'($urandom);
        wq = '{w0, w1};
        send_burst(0, k);
        s = k + 2;
        while (cyc < s + 69) @(negedge clk);
        check("mid_bit3", ifa.txd, w0[11]);
        check("mid_ovf_sticky", ifa.overflow, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_txd",  ifa.txd, 1);
        check("abort_busy", ifa.busy, 0);
        check("abort_full", ifa.fifo_full, 0);
        check("abort_ovf",  ifa.overflow, 0);
        rst_n = 1'b1;
        k = cyc;
        wait_past(k + 30);
        ok_txd = 1; ok_busy = 1;
        for (int i = k; i < k + 30; i++) begin
            if (txd_a[15'(i)] !== 1'b1)  ok_txd  = 0;
            if (busy_a[15'(i)] !== 1'b0) ok_busy = 0;
        end
        check("post_rst_txd",  ok_txd, 1);
        check("post_rst_busy", ok_busy, 1);
        wq = '{16'hA55A};
        send_burst(0, k);
        check_frames(0, k, 1, "after_rst");

        // Low byte first.
        wq = '{16'hA55A};
        send_burst(1, k);
        check_frames(1, k, 0, "lo_first");

        // Random bursts no longer than depth+1, so every word is accepted.
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(1, 5);
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
            send_burst(0, k);
            check_frames(0, k, 1, $sformatf("rand%0d", r));
        end
        check("rand_ovf", ifa.overflow, 0);
        check("rand_busy", ifa.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
Downstream stage of the frame address/enable generator. Accepts 16-bit frame words (header 0x5353, payload, trailer 0x4545) on a one-cycle write strobe and buffers them in a small word FIFO. Each word is serialised as two UART 8N1 bytes on a single TX line, high byte first by default. Absorbs bursts of strobes faster than the line rate and flags any dropped words.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division), must be >= 2
FIFO_DEPTH, 4, word FIFO depth; power of 2, >= 2
HI_FIRST, 1, 1 = send data_in[15:8] first; 0 = send data_in[7:0] first

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
data_in  in  16  frame word, sampled when tx_en=1
tx_en  in  1  one-cycle write strobe from upstream
txd  out  1  UART serial output, idle high
busy  out  1  high while a byte is on the line or the FIFO is non-empty
fifo_full  out  1  FIFO holds FIFO_DEPTH words
overflow  out  1  sticky: a word was dropped; cleared only by reset

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a clk edge):
  - txd=1, busy=0, fifo_full=0, overflow=0.
  - FIFO pointers and count = 0; FSM = IDLE; baud counter = 0.
  - A reset mid-frame aborts the byte immediately; txd returns to 1 on the next edge.
- FIFO write:
  - tx_en=1 and FIFO not full: data_in is written.
  - tx_en=1, FIFO full, and a pop in the same cycle: the write is accepted.
  - tx_en=1, FIFO full, no pop: the word is dropped and overflow <= 1.
  - A tx_en held high for k cycles writes k words.
- FIFO pop: occurs only in IDLE when count > 0; the popped word is latched into a 16-bit shift holding register.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If count > 0: pop, set byte_sel=0, go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: txd = current byte[bit_idx], LSB first, CLKS_PER_BIT cycles per bit. After bit 7, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles. Then:
    - if byte_sel=0: set byte_sel=1, go to START (second byte, no idle gap);
    - else: go to IDLE.
- Byte selection: with HI_FIRST=1, byte_sel=0 sends [15:8] and byte_sel=1 sends [7:0]; with HI_FIRST=0 the order is swapped.
- Latency:
  - tx_en sampled at edge N into an empty FIFO makes count=1 after N.
  - The FSM pops at edge N+1, and txd falls (start bit) after edge N+1.
- Back-to-back words: from IDLE with count > 0, the next START begins one cycle after the previous STOP ends. This gives exactly one idle-high cycle between words and none between the two bytes of a word.
- Baud counter:
  - Width is clog2(CLKS_PER_BIT).
  - Reloads to 0 on every state or bit change.
  - Each bit lasts exactly CLKS_PER_BIT cycles; no fractional correction.
- Status outputs:
  - busy = (state != IDLE) | (count != 0), registered.
  - fifo_full = (count == FIFO_DEPTH), registered.
- Widths:
  - count is clog2(FIFO_DEPTH)+1 bits; pointers are clog2(FIFO_DEPTH) bits.
  - Pointers wrap naturally at FIFO_DEPTH.

Decomposition:
- Shared package: FSM state encoding (IDLE/START/DATA/STOP, 2 bits), the UART idle level constant, and the frame marker constants 0x5353 and 0x4545 (shared with the upstream generator).
- One natural sub-module: word_fifo (parameterised width/depth, registered count/full/empty, simultaneous read/write support).
- Serialiser FSM and baud counter stay in uart_word_tx.

Test Plan:
- Test parameters: CLK_FREQ=16, BAUD=1 (CLKS_PER_BIT=16), HI_FIRST=1.
- Reset then idle 100 cycles -> txd=1, busy=0, overflow=0 throughout.
- Single strobe data_in=0x5353 -> start bit low after 2 edges, then two frames of bit sequence 0,1,1,0,0,1,0,1,0,1 (start, LSB-first 0x53, stop). Total 320 cycles, no gap between the bytes; busy falls on the cycle after the second stop bit.
- Strobes 0x5353, 0x1234, 0x4545 on consecutive cycles -> line decodes bytes 53 53 12 34 45 45 in order, with exactly one idle cycle between words; overflow stays 0.
- Six consecutive strobes (0x0001..0x0006) with FIFO_DEPTH=4 -> first word popped at edge 2, words 2-5 fill the FIFO, word 6 dropped. overflow=1 and stays 1; line carries 00 01 .. 00 05 only.
- Assert rst_n=0 during the DATA bit 3 of the first byte -> txd=1 next edge, FIFO empty, busy=0. A subsequent strobe of 0xA55A transmits A5 5A cleanly.
- HI_FIRST=0, data_in=0xA55A -> bytes on the line are 5A then A5.
